// File: rtl/unbyter.sv
// Byte-to-word bridge: packs a byte stream into DI words on writes
// and serves fetched words back one byte at a time on reads.
module unbyter #(
  parameter int DI_DATA_WIDTH = 32
) (
  input  logic                     ifclk,
  input  logic                     resetb,
  input  logic                     enable,
  input  logic [31:0]              di0_len,
  input  logic                     di0_write_mode,
  input  logic                     di0_write,
  input  logic [7:0]               di0_reg_datai,
  output logic                     di0_write_rdy,
  input  logic                     di0_read_mode,
  input  logic                     di0_read_req,
  input  logic                     di0_read,
  output logic [7:0]               di0_reg_datao,
  output logic                     di0_read_rdy,
  output logic                     di1_write,
  output logic [DI_DATA_WIDTH-1:0] di1_reg_datai,
  input  logic                     di1_write_rdy,
  output logic                     di1_read_req,
  output logic                     di1_read,
  input  logic [DI_DATA_WIDTH-1:0] di1_reg_datao,
  input  logic                     di1_read_rdy
);

  localparam int NB = DI_DATA_WIDTH / 8;
  localparam logic [2:0] NB3 = 3'(NB);

  typedef enum logic [1:0] {
    IDLE,
    W_PUSH,
    R_FETCH,
    R_SERVE
  } state_t;

  state_t                   state_q, state_nxt;
  logic [DI_DATA_WIDTH-1:0] sr_q, sr_nxt;
  logic [2:0]               pos_q, pos_nxt;
  logic [31:0]              cnt_q, cnt_nxt;
  logic                     wrdy0_q, wrdy0_nxt;
  logic                     rrdy0_q, rrdy0_nxt;
  logic                     wr_q, wr_nxt;
  logic                     rd_q, rd_nxt;
  logic                     rreq_q, rreq_nxt;

  logic [2:0]  pos_inc;
  logic [31:0] cnt_inc;
  logic        term;
  logic        clr;

  assign pos_inc = pos_q + 3'd1;
  assign cnt_inc = cnt_q + 32'd1;
  assign term    = (pos_inc == NB3) ||
                   ((di0_len != 32'd0) && (cnt_inc == di0_len));
  assign clr     = !enable || !(di0_read_mode || di0_write_mode);

  assign di0_write_rdy = wrdy0_q && (state_q != W_PUSH);
  assign di0_read_rdy  = rrdy0_q && !di0_read;
  assign di1_reg_datai = sr_q;
  assign di0_reg_datao = sr_q[7:0];
  assign di1_write     = wr_q;
  assign di1_read      = rd_q;
  assign di1_read_req  = rreq_q;

  always_comb begin
    state_nxt = state_q;
    sr_nxt    = sr_q;
    pos_nxt   = pos_q;
    cnt_nxt   = cnt_q;
    wrdy0_nxt = wrdy0_q;
    rrdy0_nxt = rrdy0_q;
    wr_nxt    = wr_q;
    rd_nxt    = rd_q;
    rreq_nxt  = rreq_q;
    if (clr) begin
      state_nxt = IDLE;
      sr_nxt    = '0;
      pos_nxt   = '0;
      cnt_nxt   = '0;
      wrdy0_nxt = 1'b1;
      rrdy0_nxt = 1'b0;
      wr_nxt    = 1'b0;
      rd_nxt    = 1'b0;
      rreq_nxt  = 1'b0;
    end else if (di0_read_mode) begin
      unique case (state_q)
        IDLE: begin
          wrdy0_nxt = 1'b1;
          if (di0_read_req) begin
            rreq_nxt  = 1'b1;
            state_nxt = R_FETCH;
          end
        end
        R_FETCH: begin
          rd_nxt = di1_read_rdy && !rd_q;
          if (rd_q) begin
            sr_nxt    = di1_reg_datao;
            rreq_nxt  = 1'b0;
            rrdy0_nxt = 1'b1;
            pos_nxt   = '0;
            state_nxt = R_SERVE;
          end
        end
        R_SERVE: begin
          if (di0_read && rrdy0_q) begin
            sr_nxt  = sr_q >> 8;
            pos_nxt = pos_inc;
            cnt_nxt = cnt_inc;
            if (term) begin
              rrdy0_nxt = 1'b0;
              state_nxt = IDLE;
            end
          end
        end
        W_PUSH: begin
          // switching direction abandons the pending word
          wr_nxt    = 1'b0;
          sr_nxt    = '0;
          pos_nxt   = '0;
          wrdy0_nxt = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          wrdy0_nxt = 1'b1;
          if (di0_write && wrdy0_q) begin
            sr_nxt[{pos_q, 3'b000} +: 8] = di0_reg_datai;
            pos_nxt = pos_inc;
            cnt_nxt = cnt_inc;
            if (term) begin
              wrdy0_nxt = 1'b0;
              state_nxt = W_PUSH;
            end
          end
        end
        W_PUSH: begin
          if (wr_q) begin
            wr_nxt    = 1'b0;
            sr_nxt    = '0;
            pos_nxt   = '0;
            wrdy0_nxt = 1'b1;
            state_nxt = IDLE;
          end else if (di1_write_rdy) begin
            wr_nxt = 1'b1;
          end
        end
        R_FETCH, R_SERVE: begin
          rd_nxt    = 1'b0;
          rreq_nxt  = 1'b0;
          rrdy0_nxt = 1'b0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      sr_q    <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
      wrdy0_q <= 1'b0;
      rrdy0_q <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rreq_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      sr_q    <= sr_nxt;
      pos_q   <= pos_nxt;
      cnt_q   <= cnt_nxt;
      wrdy0_q <= wrdy0_nxt;
      rrdy0_q <= rrdy0_nxt;
      wr_q    <= wr_nxt;
      rd_q    <= rd_nxt;
      rreq_q  <= rreq_nxt;
    end
  end

endmodule

// File: tb/tb_unbyter.sv
// Bench for unbyter: 32- and 16-bit instances share stimulus,
// a scoreboard checks pushed words and served bytes.
module tb_unbyter;

  logic        ifclk = 1'b0;
  logic        resetb;
  logic        en32, en16, sel16;
  logic [31:0] di0_len;
  logic        wm, dw, rm, rreq, rd;
  logic [7:0]  wdat;
  logic        di1_wrdy, di1_rrdy;
  logic [31:0] rdata;

  logic        w32_rdy, r32_rdy, wr32, rreq32, rd32;
  logic [7:0]  do32;
  logic [31:0] dat32;
  logic        w16_rdy, r16_rdy, wr16, rreq16, rd16;
  logic [7:0]  do16;
  logic [15:0] dat16;

  logic        w_rdy, r_rdy, wr_s, rd_s, rreq_s;
  logic [7:0]  do_s;
  logic [31:0] dat_s;

  logic [31:0] rd_arr [16];
  logic [3:0]  rd_idx = '0;
  logic [31:0] exp_words [$];
  logic [7:0]  exp_bytes [$];
  logic [7:0]  wb [16];
  int          checks = 0;
  int          failures = 0;
  int          wr_pulses = 0;
  int          rd_pulses = 0;
  logic        wr_prev = 1'b0;

  always #5 ifclk = ~ifclk;

  unbyter #(.DI_DATA_WIDTH(32)) u32 (
    .ifclk(ifclk), .resetb(resetb), .enable(en32),
    .di0_len(di0_len), .di0_write_mode(wm), .di0_write(dw),
    .di0_reg_datai(wdat), .di0_write_rdy(w32_rdy),
    .di0_read_mode(rm), .di0_read_req(rreq), .di0_read(rd),
    .di0_reg_datao(do32), .di0_read_rdy(r32_rdy),
    .di1_write(wr32), .di1_reg_datai(dat32),
    .di1_write_rdy(di1_wrdy), .di1_read_req(rreq32),
    .di1_read(rd32), .di1_reg_datao(rdata),
    .di1_read_rdy(di1_rrdy)
  );

  unbyter #(.DI_DATA_WIDTH(16)) u16 (
    .ifclk(ifclk), .resetb(resetb), .enable(en16),
    .di0_len(di0_len), .di0_write_mode(wm), .di0_write(dw),
    .di0_reg_datai(wdat), .di0_write_rdy(w16_rdy),
    .di0_read_mode(rm), .di0_read_req(rreq), .di0_read(rd),
    .di0_reg_datao(do16), .di0_read_rdy(r16_rdy),
    .di1_write(wr16), .di1_reg_datai(dat16),
    .di1_write_rdy(di1_wrdy), .di1_read_req(rreq16),
    .di1_read(rd16), .di1_reg_datao(rdata[15:0]),
    .di1_read_rdy(di1_rrdy)
  );

  assign w_rdy  = sel16 ? w16_rdy : w32_rdy;
  assign r_rdy  = sel16 ? r16_rdy : r32_rdy;
  assign wr_s   = sel16 ? wr16 : wr32;
  assign rd_s   = sel16 ? rd16 : rd32;
  assign rreq_s = sel16 ? rreq16 : rreq32;
  assign do_s   = sel16 ? do16 : do32;
  assign dat_s  = sel16 ? {16'h0, dat16} : dat32;
  assign rdata  = rd_arr[rd_idx];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // word terminal: advance read data after each sampled di1_read
  always @(posedge ifclk)
    if (rd_s) rd_idx <= rd_idx + 4'd1;

  always @(negedge ifclk) begin
    if (wr_s) begin
      wr_pulses++;
      check("wr_pulse_len", {31'h0, wr_prev}, 0);
      if (exp_words.size() == 0) check("wr_unexpected", 1, 0);
      else check("wr_word", dat_s, exp_words.pop_front());
    end
    if (rd_s) rd_pulses++;
    wr_prev = wr_s;
  end

  task automatic tick();
    @(negedge ifclk);
  endtask

  task automatic idle_clear();
    wm = 1'b0; rm = 1'b0; dw = 1'b0; rd = 1'b0; rreq = 1'b0;
    tick(); tick();
  endtask

  task automatic wr_byte(input logic [7:0] b);
    int n = 0;
    while (!w_rdy && n < 50) begin tick(); n++; end
    if (!w_rdy) check("wr_rdy_timeout", 0, 1);
    dw = 1'b1; wdat = b;
    tick();
    dw = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_words.size() != 0 && n < 20) begin tick(); n++; end
    check("wr_drain", exp_words.size(), 0);
  endtask

  task automatic wr_seq(input int len, input int nbytes);
    logic [31:0] word = '0;
    int pos = 0;
    int nb = sel16 ? 2 : 4;
    bit t;
    for (int i = 0; i < nbytes; i++) begin
      word[8*pos +: 8] = wb[i];
      pos++;
      t = (pos == nb) || (len != 0 && i + 1 == len);
      if (t) begin
        exp_words.push_back(word);
        word = '0;
        pos = 0;
      end
      wr_byte(wb[i]);
      if (t) check("wr_rdy_after_term", {31'h0, w_rdy}, 0);
    end
    drain();
  endtask

  task automatic rd_seq(input int nbytes, input int nwords);
    int nb = sel16 ? 2 : 4;
    int p0 = rd_pulses;
    int n;
    for (int w = 0; w < nwords; w++)
      for (int k = 0; k < nb; k++)
        if (w * nb + k < nbytes)
          exp_bytes.push_back(rd_arr[rd_idx + 4'(w)][8*k +: 8]);
    for (int i = 0; i < nbytes; i++) begin
      if (i % nb == 0) begin
        rreq = 1'b1;
        tick();
        rreq = 1'b0;
        n = 0;
        while (!r_rdy && n < 30) begin tick(); n++; end
        check("rd_latency", n, 2);
      end
      n = 0;
      while (!r_rdy && n < 30) begin tick(); n++; end
      check("rd_byte", {24'h0, do_s}, {24'h0, exp_bytes.pop_front()});
      rd = 1'b1;
      #1 check("rd_rdy_in_read", {31'h0, r_rdy}, 0);
      tick();
      rd = 1'b0;
    end
    check("rd_rdy_after_last", {31'h0, r_rdy}, 0);
    check("rd_pulses", rd_pulses - p0, nwords);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    resetb = 1'b0; en32 = 1'b1; en16 = 1'b0; sel16 = 1'b0;
    di0_len = 0; wm = 0; dw = 0; rm = 0; rreq = 0; rd = 0;
    wdat = 0; di1_wrdy = 1'b1; di1_rrdy = 1'b1;
    for (int i = 0; i < 16; i++) rd_arr[i] = '0;
    tick(); tick();
    check("rst_wrdy", {31'h0, w_rdy}, 0);
    check("rst_rrdy", {31'h0, r_rdy}, 0);
    check("rst_di1", {29'h0, wr_s, rd_s, rreq_s}, 0);
    check("rst_sr", dat_s, 0);
    resetb = 1'b1;
    tick();
    check("wrdy_after_rst", {31'h0, w_rdy}, 1);

    // two full words
    wm = 1'b1; di0_len = 8;
    for (int i = 0; i < 8; i++) wb[i] = 8'(8'h11 * (i + 1));
    p0 = wr_pulses;
    wr_seq(8, 8);
    check("t1_pulses", wr_pulses - p0, 2);
    idle_clear();

    // partial final word
    wm = 1'b1; di0_len = 5;
    p0 = wr_pulses;
    wr_seq(5, 5);
    repeat (4) tick();
    check("t2_pulses", wr_pulses - p0, 2);
    idle_clear();

    // stalled word terminal, ignored byte in stall
    wm = 1'b1; di0_len = 8;
    for (int i = 0; i < 3; i++) wr_byte(wb[i]);
    di1_wrdy = 1'b0;
    exp_words.push_back(32'h44332211);
    wr_byte(wb[3]);
    p0 = wr_pulses;
    for (int i = 0; i < 10; i++) begin
      dw = (i == 2); wdat = 8'h99;
      tick();
      check("stall_wrdy", {31'h0, w_rdy}, 0);
      check("stall_nowr", wr_pulses - p0, 0);
    end
    dw = 1'b0;
    di1_wrdy = 1'b1;
    tick();
    check("stall_pulse", {31'h0, wr_s}, 1);
    exp_words.push_back(32'h88776655);
    for (int i = 4; i < 8; i++) wr_byte(wb[i]);
    drain();
    idle_clear();

    // reads, 32-bit
    rm = 1'b1; di0_len = 6;
    rd_arr[rd_idx] = 32'hDDCCBBAA;
    rd_arr[rd_idx + 4'd1] = 32'h0000FFEE;
    rd_seq(6, 2);
    idle_clear();

    // 16-bit write then unbounded read
    en32 = 1'b0; en16 = 1'b1; sel16 = 1'b1;
    tick();
    wm = 1'b1; di0_len = 3;
    wb[0] = 8'hA1; wb[1] = 8'hB2; wb[2] = 8'hC3;
    p0 = wr_pulses;
    wr_seq(3, 3);
    check("t5_pulses", wr_pulses - p0, 2);
    idle_clear();
    rm = 1'b1; di0_len = 0;
    rd_arr[rd_idx] = 32'h2211;
    rd_arr[rd_idx + 4'd1] = 32'h4433;
    rd_seq(4, 2);
    idle_clear();

    // enable drop discards partial word
    en16 = 1'b0; en32 = 1'b1; sel16 = 1'b0;
    tick();
    wm = 1'b1; di0_len = 4;
    p0 = wr_pulses;
    wr_byte(8'h11); wr_byte(8'h22);
    en32 = 1'b0;
    tick();
    check("en_drop_wrdy", {31'h0, w_rdy}, 1);
    en32 = 1'b1;
    for (int i = 0; i < 4; i++) wb[i] = 8'(8'hA0 + i);
    wr_seq(4, 4);
    repeat (3) tick();
    check("t6_pulses", wr_pulses - p0, 1);
    idle_clear();

    // async reset mid-transfer
    wm = 1'b1; di0_len = 0;
    wr_byte(8'h5A); wr_byte(8'hC3);
    #2 resetb = 1'b0;
    #1 check("arst_wrdy", {31'h0, w_rdy}, 0);
    check("arst_sr", dat_s, 0);
    tick();
    resetb = 1'b1;
    tick();
    check("arst_recover", {31'h0, w_rdy}, 1);
    check("no_leftover", exp_words.size() + exp_bytes.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
